// File: rtl/axis_dual_input_to_output.sv
// Two-port AXI-Stream merge with main output register plus one skid slot.
// Define AXIS_MERGE_ROUND_ROBIN_EN for alternating arbitration; default is port-0 priority.
module axis_dual_input_to_output #(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_axis_tvalid_0,
    input  logic signed [WIDTH-1:0] s_axis_tdata_0,
    output logic                    s_axis_tready_0,
    input  logic                    s_axis_tvalid_1,
    input  logic signed [WIDTH-1:0] s_axis_tdata_1,
    output logic                    s_axis_tready_1,
    output logic                    m_axis_tvalid,
    output logic signed [WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_tid,
    input  logic                    m_axis_tready
);

    logic                    main_valid_q, main_valid_d;
    logic signed [WIDTH-1:0] main_data_q, main_data_d;
    logic                    main_id_q, main_id_d;
    logic                    skid_valid_q, skid_valid_d;
    logic signed [WIDTH-1:0] skid_data_q, skid_data_d;
    logic                    skid_id_q, skid_id_d;
    logic                    last_grant_q, last_grant_d;

    logic                    ready;
    logic                    grant_0, grant_1;
    logic                    accept;
    logic signed [WIDTH-1:0] in_data;

    always_comb begin
        grant_0 = 1'b0;
        grant_1 = 1'b0;
        if (s_axis_tvalid_0 && s_axis_tvalid_1) begin
`ifdef AXIS_MERGE_ROUND_ROBIN_EN
            grant_0 = last_grant_q;
            grant_1 = !last_grant_q;
`else
            grant_0 = 1'b1;
`endif
        end else begin
            grant_0 = s_axis_tvalid_0;
            grant_1 = s_axis_tvalid_1;
        end
    end

    // rst gating keeps tready low for the whole reset pulse
    assign ready           = !skid_valid_q && !rst;
    assign s_axis_tready_0 = ready && grant_0;
    assign s_axis_tready_1 = ready && grant_1;

    assign accept  = (s_axis_tvalid_0 && s_axis_tready_0)
                   || (s_axis_tvalid_1 && s_axis_tready_1);
    assign in_data = grant_1 ? s_axis_tdata_1 : s_axis_tdata_0;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_id_d    = main_id_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_id_d    = skid_id_q;
        last_grant_d = last_grant_q;

        if (main_valid_q && skid_valid_q && m_axis_tready) begin
            main_valid_d = 1'b1;
            main_data_d  = skid_data_q;
            main_id_d    = skid_id_q;
            skid_valid_d = 1'b0;
        end else if (accept) begin
            last_grant_d = grant_1;
            if (!main_valid_q || m_axis_tready) begin
                main_valid_d = 1'b1;
                main_data_d  = in_data;
                main_id_d    = grant_1;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
                skid_id_d    = grant_1;
            end
        end else if (main_valid_q && m_axis_tready) begin
            main_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_id_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_id_q    <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_id_q    <= main_id_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_id_q    <= skid_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign m_axis_tvalid = main_valid_q;
    assign m_axis_tdata  = main_data_q;
    assign m_axis_tid    = main_id_q;

endmodule

// File: tb/tb_axis_dual_input_to_output.sv
// Directed self-checking bench for axis_dual_input_to_output.
// Honors AXIS_MERGE_ROUND_ROBIN_EN to select expected arbitration results.
module tb_axis_dual_input_to_output;

    localparam int WIDTH = 16;

    logic                    clk;
    logic                    rst;
    logic                    s_axis_tvalid_0;
    logic signed [WIDTH-1:0] s_axis_tdata_0;
    logic                    s_axis_tready_0;
    logic                    s_axis_tvalid_1;
    logic signed [WIDTH-1:0] s_axis_tdata_1;
    logic                    s_axis_tready_1;
    logic                    m_axis_tvalid;
    logic signed [WIDTH-1:0] m_axis_tdata;
    logic                    m_axis_tid;
    logic                    m_axis_tready;

    int n_checks;
    int n_fails;

    axis_dual_input_to_output #(.WIDTH(WIDTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .s_axis_tvalid_0 (s_axis_tvalid_0),
        .s_axis_tdata_0  (s_axis_tdata_0),
        .s_axis_tready_0 (s_axis_tready_0),
        .s_axis_tvalid_1 (s_axis_tvalid_1),
        .s_axis_tdata_1  (s_axis_tdata_1),
        .s_axis_tready_1 (s_axis_tready_1),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tid      (m_axis_tid),
        .m_axis_tready   (m_axis_tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input int v, input int d,
                             input int id);
        check({tag, ".tvalid"}, int'(m_axis_tvalid), v);
        check({tag, ".tdata"}, int'(m_axis_tdata), d);
        check({tag, ".tid"}, int'(m_axis_tid), id);
    endtask

    initial begin
        int exp_d;
        int exp_id;
        int rr;
        n_checks = 0;
        n_fails  = 0;
`ifdef AXIS_MERGE_ROUND_ROBIN_EN
        rr = 1;
`else
        rr = 0;
`endif
        rst             = 1'b1;
        s_axis_tvalid_0 = 1'b1;
        s_axis_tdata_0  = 16'sd5;
        s_axis_tvalid_1 = 1'b1;
        s_axis_tdata_1  = 16'sd6;
        m_axis_tready   = 1'b0;

        // reset state
        @(negedge clk);
        @(negedge clk);
        check_out("reset", 0, 0, 0);
        check("reset.tready0", int'(s_axis_tready_0), 0);
        check("reset.tready1", int'(s_axis_tready_1), 0);

        // both ports streaming, downstream always ready
        rst           = 1'b0;
        m_axis_tready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (rr != 0) begin
                exp_id = k % 2;
                exp_d  = (exp_id != 0) ? -200 - k / 2 : 100 + k / 2;
            end else begin
                exp_id = 0;
                exp_d  = 100 + k;
            end
            s_axis_tdata_0 = 16'(rr != 0 ? 100 + k / 2 : 100 + k);
            s_axis_tdata_1 = 16'(-200 - k / 2);
            #1;
            check("stream.tready0", int'(s_axis_tready_0), exp_id == 0 ? 1 : 0);
            check("stream.tready1", int'(s_axis_tready_1), exp_id);
            @(negedge clk);
            check_out("stream.out", 1, exp_d, exp_id);
        end
        s_axis_tvalid_0 = 1'b0;
        s_axis_tvalid_1 = 1'b0;
        @(negedge clk);
        check("stream.drain", int'(m_axis_tvalid), 0);

        // port 1 alone under downstream stall
        m_axis_tready   = 1'b0;
        s_axis_tvalid_1 = 1'b1;
        s_axis_tdata_1  = 16'sd7;
        #1;
        check("stall.tready1_a", int'(s_axis_tready_1), 1);
        @(negedge clk);
        check_out("stall.hold1", 1, 7, 1);
        s_axis_tdata_1 = 16'sd8;
        #1;
        check("stall.tready1_b", int'(s_axis_tready_1), 1);
        @(negedge clk);
        check_out("stall.hold2", 1, 7, 1);
        s_axis_tdata_1 = 16'sd9;
        #1;
        check("stall.tready1_full", int'(s_axis_tready_1), 0);
        @(negedge clk);
        check_out("stall.hold3", 1, 7, 1);
        check("stall.tready1_full2", int'(s_axis_tready_1), 0);
        s_axis_tvalid_1 = 1'b0;
        m_axis_tready   = 1'b1;
        @(negedge clk);
        check_out("stall.skid_out", 1, 8, 1);
        @(negedge clk);
        check("stall.empty", int'(m_axis_tvalid), 0);

        // main and skid full, one-cycle release moves skid to main only
        m_axis_tready   = 1'b0;
        s_axis_tvalid_0 = 1'b1;
        s_axis_tdata_0  = 16'sd10;
        @(negedge clk);
        s_axis_tdata_0 = 16'sd11;
        @(negedge clk);
        s_axis_tdata_0 = 16'sd12;
        m_axis_tready  = 1'b1;
        #1;
        check("full.no_accept", int'(s_axis_tready_0), 0);
        check_out("full.main", 1, 10, 0);
        @(negedge clk);
        check_out("full.skid_moved", 1, 11, 0);
        m_axis_tready = 1'b0;
        #1;
        check("full.ready_again", int'(s_axis_tready_0), 1);
        @(negedge clk);
        check_out("full.held", 1, 11, 0);
        s_axis_tvalid_0 = 1'b0;
        m_axis_tready   = 1'b1;
        @(negedge clk);
        check_out("full.order", 1, 12, 0);
        @(negedge clk);
        check("full.empty", int'(m_axis_tvalid), 0);

        // reset while main and skid hold port-0 beats
        m_axis_tready   = 1'b0;
        s_axis_tvalid_0 = 1'b1;
        s_axis_tdata_0  = 16'sd30;
        @(negedge clk);
        s_axis_tdata_0 = 16'sd31;
        @(negedge clk);
        check_out("prerst.main", 1, 30, 0);
        s_axis_tvalid_1 = 1'b1;
        s_axis_tdata_0  = 16'sd40;
        s_axis_tdata_1  = -16'sd50;
        #2;
        rst = 1'b1;
        #1;
        check_out("async_rst", 0, 0, 0);
        check("async_rst.tready0", int'(s_axis_tready_0), 0);
        check("async_rst.tready1", int'(s_axis_tready_1), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("postrst.tready0", int'(s_axis_tready_0), 1);
        check("postrst.tready1", int'(s_axis_tready_1), 0);
        @(negedge clk);
        check_out("postrst.first", 1, 40, 0);
        s_axis_tvalid_0 = 1'b0;
        s_axis_tvalid_1 = 1'b0;
        m_axis_tready   = 1'b1;
        @(negedge clk);
        check("postrst.no_stale", int'(m_axis_tvalid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/axis_dual_input_to_output.md
AXIS_DUAL_INPUT_TO_OUTPUT -- requirements
Module: axis_dual_input_to_output

Interface
REQ-001 SHALL have parameter: WIDTH, 16, sample width in bits (signed).
REQ-002 SHALL have ports: clk  input  1  single clock; all logic is rising-edge.
REQ-003 SHALL have ports: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: s_axis_tvalid_0  input  1  port-0 sample valid.
REQ-005 SHALL have ports: s_axis_tdata_0  input  WIDTH signed  port-0 sample.
REQ-006 SHALL have ports: s_axis_tready_0  output  1  port-0 accept.
REQ-007 SHALL have ports: s_axis_tvalid_1, s_axis_tdata_1, s_axis_tready_1, identical to port 0, for port 1.
REQ-008 SHALL have ports: m_axis_tvalid  output  1  merged sample valid.
REQ-009 SHALL have ports: m_axis_tdata  output  WIDTH signed  merged sample.
REQ-010 SHALL have ports: m_axis_tid  output  1  source port of m_axis_tdata (0 or 1).
REQ-011 SHALL have ports: m_axis_tready  input  1  downstream accept.

Function
REQ-012 SHALL merge two AXI-Stream slave ports into one master port, one beat accepted per cycle, data passed unmodified.
REQ-013 SHALL contain a main output register (valid, data, id) driving m_axis_* directly, plus one skid register (valid, data, id).
REQ-014 SHALL derive internal ready as NOT skid_valid; s_axis_tready_x = internal ready AND grant_x.
REQ-015 Grant: only one tvalid high -> that port; none high -> no grant, both treadys low; both high -> arbitration per REQ-027/028.
REQ-016 Transfer on port x occurs when s_axis_tvalid_x AND s_axis_tready_x; at most one port transfers per cycle.
REQ-017 Accepted beat SHALL load the main register if main is empty or m_axis_tready is high that cycle; otherwise load the skid register.
REQ-018 When main valid, skid valid, and m_axis_tready high: main <= skid, skid cleared, no input accepted that cycle.
REQ-019 Main cleared when m_axis_tready high, main valid, and no replacement beat (no accept, skid empty).
REQ-020 Latency: accepted beat appears on m_axis_* the next cycle when main is empty or draining.
REQ-021 Ordering SHALL be preserved: skid content always leaves before any later-accepted beat.
REQ-022 m_axis_tvalid, m_axis_tdata, m_axis_tid SHALL stay stable while m_axis_tvalid high and m_axis_tready low.
REQ-023 last_grant register SHALL update to the port index on every accepted beat only.
REQ-024 Sustained throughput SHALL be one beat per cycle with m_axis_tready held high.

Reset
REQ-025 On rst high (asynchronous): main and skid valid = 0, data = 0, id = 0; last_grant = 1; m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tid = 0.
REQ-026 Reset mid-stream SHALL discard held beats; s_axis_tready_x low while rst high; first grant after reset when both valid is port 0.

Configuration
REQ-027 With macro AXIS_MERGE_ROUND_ROBIN_EN defined: both valid -> grant port NOT last_grant (alternating).
REQ-028 Without AXIS_MERGE_ROUND_ROBIN_EN: both valid -> port 0 always wins (fixed priority); last_grant kept but unused.

Verification
REQ-029 Both ports valid continuously (port0 data 100,101,..; port1 -200,-201,..), m_axis_tready=1, RR enabled -> output 100/id0, -200/id1, 101/id0, -201/id1, one per cycle.
REQ-030 Same stimulus, macro undefined -> output 100,101,102.. all id0; s_axis_tready_1 stays 0.
REQ-031 Port1 only sends 7, m_axis_tready=0 for 3 cycles -> 7/id1 held stable 3 cycles; second beat 8 goes to skid; s_axis_tready_1 drops to 0; release -> 7 then 8, no loss.
REQ-032 Output stall with both skid and main full, then m_axis_tready=1 for 1 cycle -> main<=skid, no input accepted that cycle, order preserved.
REQ-033 Assert rst while main and skid hold data -> m_axis_tvalid=0, m_axis_tdata=0 immediately (asynchronously); after release with both valid, port 0 granted first.
